// File: rtl/alu_seq_param.sv
// Purpose: multi-cycle WIDTH-scalable ALU with iterative MUL/DIV and a start/busy/done handshake.
// Latency: single-cycle ops complete on the accepting edge; MUL and DIV (B!=0) take WIDTH more edges.
// Backpressure: none; calculate is taken only in IDLE/DONE and is dropped while an iterative op runs.
//
// Ports:
//   pulse      clock, every state update on the rising edge
//   reset      synchronous active-high reset, takes priority over calculate
//   calculate  start strobe; opcode/opA/opB are captured on the accepting edge
//   opcode     0 ADD 1 SUB 2 MUL 3 DIV 4 AND 5 OR 6 XOR 7 NOT 8 SHL 9 SHR 10 ROL 11 ROR 12 CMP
//   opA, opB   WIDTH-bit operands
//   coreOut    2*WIDTH result register, held until the next accepted op
//   opComplete one-cycle done pulse
//   busy       high while MUL/DIV iterates
//   err        divide-by-zero or illegal opcode, held alongside coreOut
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               pulse,
  input  logic               reset,
  input  logic               calculate,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  output logic [2*WIDTH-1:0] coreOut,
  output logic               opComplete,
  output logic               busy,
  output logic               err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] WBITS = WIDTH[SHW:0];

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               state;
  logic [SHW-1:0]       counter;
  logic                 isDiv;
  logic [2*WIDTH-1:0]   accReg;   // MUL accumulator
  logic [2*WIDTH-1:0]   mcand;    // MUL multiplicand, shifted left each step
  logic [WIDTH-1:0]     shReg;    // MUL: multiplier shifting right; DIV: dividend in / quotient out
  logic [WIDTH-1:0]     bReg;     // DIV divisor
  logic [WIDTH-1:0]     remReg;   // DIV partial remainder

  // ---------------- single-cycle result path ----------------
  logic [2*WIDTH-1:0] aExt, bExt, singleRes;
  logic               singleErr;
  logic [SHW-1:0]     shAmt;
  logic [SHW:0]       rotBack;
  logic [WIDTH-1:0]   rotL, rotR;
  logic               startIter;

  assign aExt    = {{WIDTH{1'b0}}, opA};
  assign bExt    = {{WIDTH{1'b0}}, opB};
  assign shAmt   = opB[SHW-1:0];
  // Complementary shift for rotates; at shAmt==0 it equals WIDTH and shifts everything out.
  assign rotBack = WBITS - {1'b0, shAmt};
  assign rotL    = (opA << shAmt) | (opA >> rotBack);
  assign rotR    = (opA >> shAmt) | (opA << rotBack);

  assign startIter = calculate &&
                     ((opcode == OP_MUL) || ((opcode == OP_DIV) && (opB != '0)));

  always_comb begin
    singleRes = '0;
    singleErr = 1'b0;
    case (opcode)
      OP_ADD: singleRes = aExt + bExt;
      OP_SUB: singleRes = aExt - bExt;  // 2*WIDTH wraparound gives the sign extension
      OP_AND: singleRes = {{WIDTH{1'b0}}, opA & opB};
      OP_OR:  singleRes = {{WIDTH{1'b0}}, opA | opB};
      OP_XOR: singleRes = {{WIDTH{1'b0}}, opA ^ opB};
      OP_NOT: singleRes = {{WIDTH{1'b0}}, ~opA};
      OP_SHL: singleRes = aExt << shAmt;
      OP_SHR: singleRes = aExt >> shAmt;
      OP_ROL: singleRes = {{WIDTH{1'b0}}, rotL};
      OP_ROR: singleRes = {{WIDTH{1'b0}}, rotR};
      OP_CMP: singleRes = {{(2*WIDTH-3){1'b0}}, opA > opB, opA == opB, opA < opB};
      OP_DIV: begin  // only reaches here with opB == 0
        singleRes = '1;
        singleErr = 1'b1;
      end
      OP_MUL: singleRes = '0;  // always iterative
      default: singleErr = 1'b1;
    endcase
  end

  // ---------------- iterative step datapath ----------------
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   remNext, quoNext;

  assign mulNext  = accReg + (shReg[0] ? mcand : '0);
  assign divShift = {remReg, shReg[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, bReg};
  // When divGe the true difference is < bReg, so a WIDTH-bit subtract is exact.
  assign remNext  = divGe ? (divShift[WIDTH-1:0] - bReg) : divShift[WIDTH-1:0];
  assign quoNext  = {shReg[WIDTH-2:0], divGe};

  always_ff @(posedge pulse) begin
    if (reset) begin
      state      <= IDLE;
      coreOut    <= '0;
      opComplete <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      counter    <= '0;
      isDiv      <= 1'b0;
      accReg     <= '0;
      mcand      <= '0;
      shReg      <= '0;
      bReg       <= '0;
      remReg     <= '0;
    end else begin
      opComplete <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (calculate) begin
            if (startIter) begin
              state   <= ITER;
              busy    <= 1'b1;
              err     <= 1'b0;
              counter <= SHW'(WIDTH - 1);
              isDiv   <= (opcode == OP_DIV);
              accReg  <= '0;
              remReg  <= '0;
              mcand   <= aExt;
              bReg    <= opB;
              shReg   <= (opcode == OP_DIV) ? opA : opB;
            end else begin
              state      <= DONE;
              coreOut    <= singleRes;
              err        <= singleErr;
              opComplete <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          if (isDiv) begin
            remReg <= remNext;
            shReg  <= quoNext;
          end else begin
            accReg <= mulNext;
            mcand  <= mcand << 1;
            shReg  <= shReg >> 1;
          end
          if (counter == '0) begin
            coreOut    <= isDiv ? {remNext, quoNext} : mulNext;
            busy       <= 1'b0;
            opComplete <= 1'b1;
            state      <= DONE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Purpose: scoreboard bench for alu_seq_param at WIDTH=8 and WIDTH=16.
// Latency: expected completion cycle is recorded with each stimulus and compared on opComplete.
// Backpressure: checks that calculate during ITER is ignored and that reset aborts an op.
module tb_alu_seq_param;

  logic        pulse = 1'b0;
  logic        reset;
  logic        calculate;
  logic [3:0]  opcode;
  logic [7:0]  opA, opB;
  logic [15:0] coreOut;
  logic        opComplete, busy, err;

  logic        calc16;
  logic [3:0]  op16;
  logic [15:0] a16, b16;
  logic [31:0] out16;
  logic        done16, busy16, err16;

  always #5 pulse = ~pulse;

  alu_seq_param #(.WIDTH(8)) dut8 (
    .pulse(pulse), .reset(reset), .calculate(calculate), .opcode(opcode),
    .opA(opA), .opB(opB), .coreOut(coreOut), .opComplete(opComplete),
    .busy(busy), .err(err)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .pulse(pulse), .reset(reset), .calculate(calc16), .opcode(op16),
    .opA(a16), .opB(b16), .coreOut(out16), .opComplete(done16),
    .busy(busy16), .err(err16)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        err;
    int          doneCyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge pulse) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Scoreboard monitors: every opComplete must match the oldest pending expectation.
  always @(negedge pulse) begin
    if (opComplete === 1'b1) begin
      if (q8.size() == 0) begin
        checkVal("spurious_done8", {31'b0, opComplete}, 32'd0);
      end else begin
        e8 = q8.pop_front();
        checkVal({e8.name, "_res"}, {16'b0, coreOut}, e8.res);
        checkVal({e8.name, "_err"}, {31'b0, err}, {31'b0, e8.err});
        checkVal({e8.name, "_lat"}, cyc, e8.doneCyc);
      end
    end
  end

  always @(negedge pulse) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        checkVal("spurious_done16", {31'b0, done16}, 32'd0);
      end else begin
        e16 = q16.pop_front();
        checkVal({e16.name, "_res"}, out16, e16.res);
        checkVal({e16.name, "_err"}, {31'b0, err16}, {31'b0, e16.err});
        checkVal({e16.name, "_lat"}, cyc, e16.doneCyc);
      end
    end
  end

  task automatic startOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] res, input logic e, input int lat, input string name);
    exp_t x;
    @(negedge pulse);
    opcode = op; opA = a; opB = b; calculate = 1'b1;
    x.name = name; x.res = {16'b0, res}; x.err = e; x.doneCyc = cyc + 1 + lat;
    q8.push_back(x);
    @(negedge pulse);
    calculate = 1'b0;
  endtask

  task automatic startOp16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] res, input logic e, input int lat,
                           input string name, input bit now);
    exp_t x;
    if (!now) @(negedge pulse);
    op16 = op; a16 = a; b16 = b; calc16 = 1'b1;
    x.name = name; x.res = res; x.err = e; x.doneCyc = cyc + 1 + lat;
    q16.push_back(x);
    @(negedge pulse);
    calc16 = 1'b0;
  endtask

  task automatic waitIdle();
    #1;
    for (int i = 0; i < 60; i++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      @(negedge pulse);
      #1;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      checkVal("timeout_pending", 32'(q8.size() + q16.size()), 32'd0);
      q8.delete();
      q16.delete();
    end
  endtask

  task automatic waitDone16();
    for (int i = 0; i < 40; i++) begin
      if (done16 === 1'b1) break;
      @(negedge pulse);
    end
    checkVal("done16_seen", {31'b0, done16}, 32'd1);
  endtask

  initial begin
    int          bc;
    logic [7:0]  ra, rb, qv, rv;
    logic [15:0] pv;

    reset = 1'b1; calculate = 1'b0; opcode = '0; opA = '0; opB = '0;
    calc16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge pulse);
    checkVal("rst_coreOut", {16'b0, coreOut}, 32'd0);
    checkVal("rst_opComplete", {31'b0, opComplete}, 32'd0);
    checkVal("rst_busy", {31'b0, busy}, 32'd0);
    checkVal("rst_err", {31'b0, err}, 32'd0);
    checkVal("rst_out16", out16, 32'd0);
    checkVal("rst_done16", {31'b0, done16}, 32'd0);
    reset = 1'b0;

    startOp(4'd0, 8'd127, 8'd126, 16'h00FD, 1'b0, 0, "add"); waitIdle();
    startOp(4'd1, 8'd126, 8'd127, 16'hFFFF, 1'b0, 0, "sub"); waitIdle();

    startOp(4'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 8, "mul");
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      if (opComplete === 1'b1) break;
      if (busy === 1'b1) bc++;
      @(negedge pulse);
    end
    checkVal("mul_busy_cycles", bc, 32'd8);
    checkVal("mul_busy_low_at_done", {31'b0, busy}, 32'd0);
    waitIdle();

    startOp(4'd3, 8'd200, 8'd7, 16'h041C, 1'b0, 8, "div"); waitIdle();
    startOp(4'd3, 8'd5, 8'd0, 16'hFFFF, 1'b1, 0, "div0"); waitIdle();
    startOp(4'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 0, "add_clr_err"); waitIdle();
    startOp(4'd8, 8'hF0, 8'd3, 16'h0780, 1'b0, 0, "shl3"); waitIdle();
    startOp(4'd8, 8'hFF, 8'd7, 16'h7F80, 1'b0, 0, "shl7"); waitIdle();
    startOp(4'd9, 8'hF0, 8'd4, 16'h000F, 1'b0, 0, "shr4"); waitIdle();
    startOp(4'd10, 8'hAF, 8'd3, 16'h007D, 1'b0, 0, "rol3"); waitIdle();
    startOp(4'd10, 8'hAF, 8'd0, 16'h00AF, 1'b0, 0, "rol0"); waitIdle();
    startOp(4'd11, 8'h81, 8'd1, 16'h00C0, 1'b0, 0, "ror1"); waitIdle();
    startOp(4'd4, 8'hCC, 8'hAA, 16'h0088, 1'b0, 0, "and"); waitIdle();
    startOp(4'd5, 8'hCC, 8'hAA, 16'h00EE, 1'b0, 0, "or"); waitIdle();
    startOp(4'd6, 8'hCC, 8'hAA, 16'h0066, 1'b0, 0, "xor"); waitIdle();
    startOp(4'd7, 8'hCC, 8'hAA, 16'h0033, 1'b0, 0, "not"); waitIdle();
    startOp(4'd12, 8'd10, 8'd5, 16'h0004, 1'b0, 0, "cmp_gt"); waitIdle();
    startOp(4'd12, 8'd7, 8'd7, 16'h0002, 1'b0, 0, "cmp_eq"); waitIdle();
    startOp(4'd14, 8'd3, 8'd4, 16'h0000, 1'b1, 0, "illegal14"); waitIdle();
    startOp(4'd15, 8'd3, 8'd4, 16'h0000, 1'b1, 0, "illegal15"); waitIdle();
    startOp(4'd12, 8'd5, 8'd10, 16'h0001, 1'b0, 0, "cmp_lt"); waitIdle();
    repeat (3) @(negedge pulse);
    checkVal("hold_coreOut_idle", {16'b0, coreOut}, 32'd1);
    checkVal("hold_err_idle", {31'b0, err}, 32'd0);

    // calculate pulsed mid-MUL must be ignored
    startOp(4'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 8, "mul_ignore");
    @(negedge pulse);
    calculate = 1'b1; opcode = 4'd0; opA = 8'd1; opB = 8'd2;
    @(negedge pulse);
    calculate = 1'b0;
    waitIdle();

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      pv = 16'(ra) * 16'(rb);
      qv = ra / rb;
      rv = ra % rb;
      startOp(4'd2, ra, rb, pv, 1'b0, 8, "rnd_mul"); waitIdle();
      startOp(4'd3, ra, rb, {rv, qv}, 1'b0, 8, "rnd_div"); waitIdle();
    end

    // reset at edge N+4 of a MUL: outputs cleared, no completion
    startOp(4'd3, 8'd5, 8'd0, 16'hFFFF, 1'b1, 0, "div0_pre_rst"); waitIdle();
    @(negedge pulse);
    opcode = 4'd2; opA = 8'hFF; opB = 8'hFF; calculate = 1'b1;
    @(negedge pulse);
    calculate = 1'b0;
    repeat (3) @(negedge pulse);
    reset = 1'b1;
    @(negedge pulse);
    checkVal("midrst_coreOut", {16'b0, coreOut}, 32'd0);
    checkVal("midrst_err", {31'b0, err}, 32'd0);
    checkVal("midrst_busy", {31'b0, busy}, 32'd0);
    checkVal("midrst_opComplete", {31'b0, opComplete}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge pulse);
    checkVal("midrst_coreOut_after", {16'b0, coreOut}, 32'd0);
    startOp(4'd0, 8'd3, 8'd4, 16'h0007, 1'b0, 0, "add_after_rst"); waitIdle();

    // WIDTH=16: MUL then back-to-back starts issued in the DONE cycle
    startOp16(4'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 16, "mul16", 1'b0);
    waitDone16();
    startOp16(4'd0, 16'd1, 16'd2, 32'h00000003, 1'b0, 0, "add16_b2b", 1'b1);
    waitDone16();
    startOp16(4'd3, 16'hFFFF, 16'h0100, 32'h00FF00FF, 1'b0, 16, "div16_b2b", 1'b1);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
